// File: rtl/jk_arb_pkg.sv
// Shared types for the JK bank arbiter: {J,K} command codes, arbiter states
// and the round-robin pick used to choose one requester per clock.
package jk_arb_pkg;

    localparam int MAX_REQ   = 16;
    localparam int MAX_IDX_W = 4;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_cmd_t;

    typedef enum logic {
        ARB_RR     = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // Search upward from ptr+1, wrapping at num_req. ptr < num_req and the
    // offset never exceeds num_req, so a single subtraction replaces a modulo.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0]   elig,
        input logic [MAX_IDX_W-1:0] ptr,
        input int                   num_req
    );
        rr_pick_t           res;
        logic [MAX_IDX_W:0] cand;
        res = '0;
        for (int s = 1; s <= MAX_REQ; s++) begin
            cand = {1'b0, ptr} + (MAX_IDX_W+1)'(s);
            if (cand >= (MAX_IDX_W+1)'(num_req)) begin
                cand = cand - (MAX_IDX_W+1)'(num_req);
            end
            if (!res.found && (s <= num_req) && elig[cand[MAX_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[MAX_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/jk_reg_bank.sv
// WIDTH JK flip-flops sharing one enable; q updates at the enabled edge.
// No backpressure: a command presented with en high is always applied.
module jk_reg_bank
    import jk_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] d;

    always_comb begin
        d = q;
        for (int b = 0; b < WIDTH; b++) begin
            case (jk_cmd_t'({j[b], k[b]}))
                JK_CLR:  d[b] = 1'b0;
                JK_SET:  d[b] = 1'b1;
                JK_TGL:  d[b] = ~q[b];
                default: d[b] = q[b];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin shared JK flag bank: q_o updates at the grant edge, gnt_o pulses the cycle after.
// Losers hold req_i until granted; define JK_ARB_LOCK_EN to add lock_i for exclusive ownership.
module jk_bank_arbiter
    import jk_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 8,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*WIDTH-1:0] j_i,
    input  logic [NUM_REQ*WIDTH-1:0] k_i,
`ifdef JK_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]       lock_i,
`endif
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [IDX_W-1:0]         gnt_id_o,
    output logic [WIDTH-1:0]         q_o
);

    arb_state_t         state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [IDX_W-1:0]   gnt_id_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [NUM_REQ-1:0] elig;
    logic [MAX_REQ-1:0] elig_ext;
    rr_pick_t           pick;
    logic [IDX_W-1:0]   win;
    logic [WIDTH-1:0]   win_j, win_k;
    logic               lock_req;

    // Masking with gnt_o stops a requester that still holds req in its
    // grant cycle from being served twice for one command.
    always_comb begin
        elig = req_i & ~gnt_o;
        if (state == ARB_LOCKED) begin
            elig = elig & (NUM_REQ'(1) << owner);
        end
        elig_ext                = '0;
        elig_ext[NUM_REQ-1:0]   = elig;
        pick                    = rr_pick(elig_ext, MAX_IDX_W'(ptr), NUM_REQ);
        win                     = IDX_W'(pick.idx);
    end

    assign win_j = j_i[win*WIDTH +: WIDTH];
    assign win_k = k_i[win*WIDTH +: WIDTH];

`ifdef JK_ARB_LOCK_EN
    assign lock_req = lock_i[win];
`else
    assign lock_req = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        ptr_nxt    = ptr;
        gnt_id_nxt = gnt_id_o;
        gnt_nxt    = '0;
        if (pick.found) begin
            ptr_nxt    = win;
            gnt_id_nxt = win;
            gnt_nxt    = NUM_REQ'(1) << win;
            case (state)
                ARB_RR: begin
                    if (lock_req) begin
                        state_nxt = ARB_LOCKED;
                        owner_nxt = win;
                    end
                end
                ARB_LOCKED: begin
                    if (!lock_req) begin
                        state_nxt = ARB_RR;
                    end
                end
                default: state_nxt = ARB_RR;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_RR;
            ptr      <= IDX_W'(NUM_REQ - 1);
            owner    <= '0;
            gnt_o    <= '0;
            gnt_id_o <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            gnt_o    <= gnt_nxt;
            gnt_id_o <= gnt_id_nxt;
        end
    end

    jk_reg_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk (clk),
        .rst (rst),
        .en  (pick.found),
        .j   (win_j),
        .k   (win_k),
        .q   (q_o)
    );

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: requester agents plus a queue-based
// reference model feed expected grants to an independent output monitor.
module tb_jk_bank_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_i;
    logic [N*W-1:0] j_i;
    logic [N*W-1:0] k_i;
    logic [N-1:0]   gnt_o;
    logic [1:0]     gnt_id_o;
    logic [W-1:0]   q_o;
`ifdef JK_ARB_LOCK_EN
    logic [N-1:0]   lock_i = '0;
`endif

    always #5 clk = ~clk;

    jk_bank_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_i),
        .j_i      (j_i),
        .k_i      (k_i),
        .gnt_o    (gnt_o),
        .gnt_id_o (gnt_id_o),
        .q_o      (q_o)
`ifdef JK_ARB_LOCK_EN
        , .lock_i (lock_i)
`endif
    );

    typedef struct {
        int           idx;
        logic [W-1:0] q;
    } exp_t;

    typedef enum int {P_DROP, P_REASSERT, P_HOLD, P_RAND} pol_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    pol_t         pol[N];
    bit           pend[N];
    bit           reassert[N];
    logic [W-1:0] cj[N];
    logic [W-1:0] ck[N];
    logic [W-1:0] m_q;
    int           m_last;
    int           m_gnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Bitwise JK behaviour from the truth table: set, clear, toggle masks.
    function automatic logic [W-1:0] jk_apply(input logic [W-1:0] q, input logic [W-1:0] j,
                                              input logic [W-1:0] k);
        logic [W-1:0] set_m, clr_m, tgl_m;
        set_m = j & ~k;
        clr_m = k & ~j;
        tgl_m = j & k;
        return ((q | set_m) & ~clr_m) ^ tgl_m;
    endfunction

    task automatic new_cmd(input int r);
        cj[r] = W'($urandom);
        ck[r] = W'($urandom);
    endtask

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            req_i[r]       = pend[r];
            j_i[r*W +: W]  = cj[r];
            k_i[r*W +: W]  = ck[r];
        end
    endtask

    // One cycle: agents react to the grant visible now, inputs are driven,
    // and the model predicts the winner of the coming edge.
    task automatic body();
        int win;
        int c;
        for (int r = 0; r < N; r++) begin
            if (m_gnt == r) begin
                case (pol[r])
                    P_DROP:     pend[r] = 1'b0;
                    P_REASSERT: begin pend[r] = 1'b0; reassert[r] = 1'b1; end
                    P_HOLD:     ;
                    default:    if ($urandom_range(1, 0) == 1) pend[r] = 1'b0; else new_cmd(r);
                endcase
            end else if (reassert[r]) begin
                reassert[r] = 1'b0;
                pend[r]     = 1'b1;
                new_cmd(r);
            end else if (pol[r] == P_RAND && !pend[r] && $urandom_range(2, 0) == 0) begin
                pend[r] = 1'b1;
                new_cmd(r);
            end
        end
        drive();
        win = -1;
        for (int i = 1; i <= N; i++) begin
            c = (m_last + i) % N;
            if (win < 0 && pend[c] && c != m_gnt) win = c;
        end
        if (win >= 0) begin
            m_q    = jk_apply(m_q, cj[win], ck[win]);
            m_last = win;
            sb.push_back('{win, m_q});
        end
        m_gnt = win;
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
        check("q_track", q_o, m_q);
        body();
    endtask

    function automatic bit idle();
        bit b;
        b = 1'b1;
        for (int r = 0; r < N; r++) if (pend[r] || reassert[r]) b = 1'b0;
        return b;
    endfunction

    task automatic drain();
        int n;
        for (int r = 0; r < N; r++) pol[r] = P_DROP;
        n = 0;
        while (!idle() && n < 100) begin
            tick();
            n++;
        end
        if (!idle()) begin
            checks++;
            errors++;
            $display("FAIL drain_budget: requesters still pending after %0d cycles", n);
        end
        tick();
    endtask

    task automatic issue(input int r, input logic [W-1:0] j, input logic [W-1:0] k);
        int n;
        pol[r]  = P_DROP;
        pend[r] = 1'b1;
        cj[r]   = j;
        ck[r]   = k;
        n = 0;
        while (pend[r] && n < 50) begin
            tick();
            n++;
        end
        if (pend[r]) begin
            checks++;
            errors++;
            $display("FAIL issue_budget: requester %0d never served", r);
        end
    endtask

    task automatic apply_reset();
        for (int r = 0; r < N; r++) begin
            pend[r]     = 1'b0;
            reassert[r] = 1'b0;
            pol[r]      = P_DROP;
        end
        m_q    = '0;
        m_last = N - 1;
        m_gnt  = -1;
    endtask

    // Monitor: at each falling edge at most one prediction is outstanding,
    // and it must match the grant the DUT shows now.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (gnt_o != '0 || sb.size() != 0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got gnt_o %b expected none", gnt_o);
                end else begin
                    e = sb.pop_front();
                    check("gnt_onehot", 64'(gnt_o), 64'(1) << e.idx);
                    check("gnt_id", 64'(gnt_id_o), 64'(e.idx));
                    check("q_at_gnt", 64'(q_o), 64'(e.q));
                end
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < N; r++) begin
            cj[r] = '0;
            ck[r] = '0;
        end
        apply_reset();
        rst = 1'b1;
        drive();
        #3;
        check("rst_q", q_o, '0);
        check("rst_gnt", gnt_o, '0);
        check("rst_gnt_id", gnt_id_o, '0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        body();

        // Directed JK commands after reset.
        issue(0, 8'hFF, 8'h00);
        check("plan_set_q", q_o, 8'hFF);
        check("plan_set_id", gnt_id_o, 2'd0);
        issue(3, 8'hF0, 8'h0F);
        check("plan_f0", q_o, 8'hF0);
        issue(2, 8'hFF, 8'hFF);
        check("plan_toggle", q_o, 8'h0F);
        issue(1, 8'h00, 8'h0F);
        check("plan_clear", q_o, 8'h00);
        issue(1, 8'h00, 8'h00);
        check("plan_hold", q_o, 8'h00);
        tick();
        tick();
        check("idle_hold", q_o, 8'h00);

        // All four requesting, each dropping in its grant cycle and reasserting.
        for (int r = 0; r < N; r++) begin
            pol[r]  = P_REASSERT;
            pend[r] = 1'b1;
            new_cmd(r);
        end
        repeat (12) tick();
        drain();

        // Reset mid-stream while requester 2 holds a request.
        for (int r = 0; r < N; r++) pol[r] = P_RAND;
        repeat (6) tick();
        @(negedge clk);
        #2;
        rst = 1'b1;
        apply_reset();
        pend[2] = 1'b1;
        cj[2]   = 8'hA5;
        ck[2]   = 8'h00;
        drive();
        #1;
        check("midrst_q", q_o, '0);
        check("midrst_gnt", gnt_o, '0);
        check("midrst_gnt_id", gnt_id_o, '0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        body();
        tick();
        check("post_rst_gnt", gnt_o, 4'b0100);
        check("post_rst_q", q_o, 8'hA5);
        drain();

        // Requester 0 never releases; 1 also holds: grants must alternate.
        pol[0]  = P_HOLD;
        pol[1]  = P_HOLD;
        pend[0] = 1'b1;
        pend[1] = 1'b1;
        new_cmd(0);
        new_cmd(1);
        repeat (10) tick();
        drain();

        // Single requester holding: served at most every other cycle.
        pol[3]  = P_HOLD;
        pend[3] = 1'b1;
        new_cmd(3);
        repeat (7) tick();
        drain();

        // Randomized traffic.
        for (int r = 0; r < N; r++) pol[r] = P_RAND;
        repeat (400) tick();
        drain();
        repeat (3) tick();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Shares one WIDTH-bit bank of JK flip-flops between NUM_REQ requesters.
- Each requester presents per-bit J/K vectors. A round-robin arbiter picks one requester per clock and applies its command to the bank with JK semantics.
- Sits between control FSMs (which set, clear and toggle flags) and the shared flag register they read.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- WIDTH, 8, number of JK flip-flops in the bank (1..32)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_i  in  NUM_REQ  per-requester command request, level held until granted
- j_i  in  NUM_REQ*WIDTH  J vector of requester r at bits [r*WIDTH +: WIDTH]
- k_i  in  NUM_REQ*WIDTH  K vector, same packing as j_i
- gnt_o  out  NUM_REQ  one-hot grant acknowledge, one-cycle pulse, registered
- gnt_id_o  out  max(1,$clog2(NUM_REQ))  index of the last winner, registered
- q_o  out  WIDTH  current bank contents

Behaviour:
- Reset (async, rst=1), all registered:
  - q_o=0, gnt_o=0, gnt_id_o=0.
  - Internal last-winner pointer = NUM_REQ-1, so requester 0 has top priority after reset.
  - Reset mid-operation discards any in-flight request. No grant is issued for it.
- Eligible set: req_i masked by gnt_o. A requester whose gnt_o is high this cycle is not eligible this cycle, so a held req is never double-granted.
- Arbitration, each rising edge with any eligible request:
  - Winner = first eligible index searching upward from (pointer+1) mod NUM_REQ, wrapping.
  - Pointer <= winner.
  - gnt_o <= one-hot(winner); gnt_id_o <= winner.
  - Bank updated at the same edge with the winner's vectors.
- No eligible request: gnt_o <= 0; bank, pointer and gnt_id_o hold.
- Per-bit bank update for bit b: q[b] <= (J&~q)|(~K&q).
  - J=0,K=0: hold.
  - J=0,K=1: clear.
  - J=1,K=0: set.
  - J=1,K=1: toggle.
- Latency: uncontended req asserted in cycle 0 -> q_o updated after edge ending cycle 0 -> gnt_o high in cycle 1.
- Requester handshake:
  - Must hold req_i, j_i and k_i stable until its gnt_o is seen.
  - In the gnt cycle it may drop req or present a new command; a new command is eligible from the next cycle.
- Throughput: one command per cycle overall; a single requester gets at most one command per two cycles.
- Contention: all NUM_REQ requesting continuously are served strictly in rotation, each once per NUM_REQ grants (within the per-requester rate limit above).
- Commands from non-winners are never merged; only the winner's vectors affect q.

Optional Feature:
- Macro: JK_ARB_LOCK_EN.
- Defined:
  - Adds input port lock_i [NUM_REQ].
  - If the winner's lock_i bit is high at its grant edge, the arbiter enters LOCKED with owner=winner.
  - In LOCKED only the owner is eligible; others wait.
  - A grant to the owner with lock_i low returns to RR (pointer=owner).
  - rst returns to RR.
- Undefined: no lock_i port; always RR.

Decomposition:
- Package jk_arb_pkg:
  - Command encodings JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TGL=2'b11 (as {J,K}).
  - Arb state typedef {ARB_RR, ARB_LOCKED}.
  - Function for round-robin pick.
- Sub-module jk_reg_bank:
  - WIDTH JK flip-flops with async active-high rst, per-bank enable en, inputs j/k, output q.
  - Top instantiates one and drives en = any grant this edge.

Test Plan:
- Reset then req_i=4'b0001, j=8'hFF, k=8'h00 -> q_o=8'hFF one edge later; gnt_o=4'b0001 next cycle; gnt_id_o=0.
- q_o=8'hF0; req 2 with j=8'hFF, k=8'hFF -> q_o=8'h0F. Then req 1 with j=8'h00, k=8'h0F -> q_o=8'h00. Then j=k=0 -> hold.
- req_i=4'b1111 held, each requester dropping req in its gnt cycle and reasserting next cycle -> grant order 0,1,2,3,0 with one grant per cycle; a holder of req in its own gnt cycle is never granted twice back-to-back.
- Assert rst for one cycle while req_i=4'b0100 mid-stream -> q_o=0, gnt_o=0 immediately; after release, requester 2 granted first.
- req_i=4'b0011, then req 0 never released -> grants alternate 0,1,0,... with no double grant to 0 in consecutive cycles.
- JK_ARB_LOCK_EN: req 1 granted with lock_i[1]=1; req 0 and req 3 pending -> only 1 granted until lock_i[1]=0 grant, then 3 before 0.
